// File: rtl/lc3_execute.sv
// LC-3 Execute stage: operand bypass, ALU, address generation, and the registered
// hand-off to MemAccess/Writeback. Optional macro LC3_EXEC_BUBBLE_EN clears control outputs on stall.
module lc3_execute #(
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_execute,
  input  logic [15:0]   IR,
  input  logic [DW-1:0] npc_out,
  input  logic [5:0]    E_control,
  input  logic [1:0]    W_control,
  input  logic          Mem_control,
  input  logic [DW-1:0] VSR1,
  input  logic [DW-1:0] VSR2,
  input  logic          bypass_alu_1,
  input  logic          bypass_alu_2,
  input  logic          bypass_mem_1,
  input  logic          bypass_mem_2,
  input  logic [DW-1:0] Mem_Bypass_Val,
  output logic [DW-1:0] aluout,
  output logic [DW-1:0] pcout,
  output logic [1:0]    W_Control_out,
  output logic          Mem_Control_out,
  output logic [DW-1:0] M_Data,
  output logic [2:0]    dr,
  output logic [2:0]    NZP,
  output logic [15:0]   IR_Exec,
  output logic [2:0]    sr1,
  output logic [2:0]    sr2
);

  logic [3:0]    opcode;
  logic [1:0]    alu_op;
  logic [1:0]    pcsel1;
  logic          pcsel2;
  logic          op2sel;

  logic [DW-1:0] aluout_reg, pcout_reg, m_data_reg;
  logic [1:0]    w_ctl_reg;
  logic          mem_ctl_reg;
  logic [2:0]    dr_reg, nzp_reg;
  logic [15:0]   ir_reg;

  logic [DW-1:0] aluout_next, pcout_next, alu_res, alu_b, offset, base;
  logic [2:0]    dr_next, nzp_next;

  logic [1:0]    byp_alu, byp_mem;
  logic [DW-1:0] vsr     [2];
  logic [DW-1:0] operand [2];

  assign opcode = IR[15:12];
  assign alu_op = E_control[5:4];
  assign pcsel1 = E_control[3:2];
  assign pcsel2 = E_control[1];
  assign op2sel = E_control[0];

  // Stores read their data register through the sr2 port.
  assign sr1 = IR[8:6];
  assign sr2 = (opcode == 4'b0011 || opcode == 4'b0111 || opcode == 4'b1011) ? IR[11:9] : IR[2:0];

  assign byp_alu = {bypass_alu_2, bypass_alu_1};
  assign byp_mem = {bypass_mem_2, bypass_mem_1};
  assign vsr[0]  = VSR1;
  assign vsr[1]  = VSR2;

  // The previous-result path beats MemAccess because it holds the younger value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    assign operand[gi] = byp_alu[gi] ? aluout_reg :
                         byp_mem[gi] ? Mem_Bypass_Val : vsr[gi];
  end

  assign alu_b = op2sel ? operand[1] : {{(DW-5){IR[4]}}, IR[4:0]};
  assign base  = pcsel2 ? npc_out : operand[0];

  always_comb begin
    alu_res = operand[0];
    case (alu_op)
      2'b00:   alu_res = operand[0] + alu_b;
      2'b01:   alu_res = operand[0] & alu_b;
      2'b10:   alu_res = ~operand[0];
      default: alu_res = operand[0];
    endcase
  end

  always_comb begin
    offset = '0;
    case (pcsel1)
      2'b00:   offset = {{(DW-11){IR[10]}}, IR[10:0]};
      2'b01:   offset = {{(DW-9){IR[8]}}, IR[8:0]};
      2'b10:   offset = {{(DW-6){IR[5]}}, IR[5:0]};
      default: offset = '0;
    endcase
  end

  assign pcout_next = base + offset;

  always_comb begin
    aluout_next = pcout_next;
    dr_next     = 3'b000;
    nzp_next    = 3'b000;
    case (opcode)
      4'b0001, 4'b0101, 4'b1001: begin
        aluout_next = alu_res;
        dr_next     = IR[11:9];
      end
      4'b0010, 4'b0110, 4'b1010, 4'b1110: dr_next = IR[11:9];
      4'b0000: nzp_next = IR[11:9];
      4'b1100: nzp_next = 3'b111;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      aluout_reg  <= '0;
      pcout_reg   <= '0;
      m_data_reg  <= '0;
      w_ctl_reg   <= '0;
      mem_ctl_reg <= 1'b0;
      dr_reg      <= '0;
      nzp_reg     <= '0;
      ir_reg      <= '0;
    end else if (enable_execute) begin
      aluout_reg  <= aluout_next;
      pcout_reg   <= pcout_next;
      m_data_reg  <= operand[1];
      w_ctl_reg   <= W_control;
      mem_ctl_reg <= Mem_control;
      dr_reg      <= dr_next;
      nzp_reg     <= nzp_next;
      ir_reg      <= IR;
    end else begin
`ifdef LC3_EXEC_BUBBLE_EN
      // A stalled branch or writeback must not fire twice downstream.
      w_ctl_reg   <= '0;
      mem_ctl_reg <= 1'b0;
      nzp_reg     <= '0;
`else
      w_ctl_reg   <= w_ctl_reg;
      mem_ctl_reg <= mem_ctl_reg;
      nzp_reg     <= nzp_reg;
`endif
    end
  end

  assign aluout          = aluout_reg;
  assign pcout           = pcout_reg;
  assign M_Data          = m_data_reg;
  assign W_Control_out   = w_ctl_reg;
  assign Mem_Control_out = mem_ctl_reg;
  assign dr              = dr_reg;
  assign NZP             = nzp_reg;
  assign IR_Exec         = ir_reg;

endmodule

// File: tb/tb_lc3_execute.sv
// Directed bench for lc3_execute: hand-computed vectors checked one cycle after each edge.
module tb_lc3_execute;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_execute;
  logic [15:0] IR, npc_out, VSR1, VSR2, Mem_Bypass_Val;
  logic [5:0]  E_control;
  logic [1:0]  W_control;
  logic        Mem_control;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [15:0] aluout, pcout, M_Data, IR_Exec;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;
  logic [2:0]  dr, NZP, sr1, sr2;

  int checks   = 0;
  int failures = 0;

  lc3_execute dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute),
    .IR(IR), .npc_out(npc_out), .E_control(E_control),
    .W_control(W_control), .Mem_control(Mem_control),
    .VSR1(VSR1), .VSR2(VSR2),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
    .Mem_Bypass_Val(Mem_Bypass_Val),
    .aluout(aluout), .pcout(pcout), .W_Control_out(W_Control_out),
    .Mem_Control_out(Mem_Control_out), .M_Data(M_Data), .dr(dr), .NZP(NZP),
    .IR_Exec(IR_Exec), .sr1(sr1), .sr2(sr2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] ir, input logic [15:0] npc, input logic [5:0] ectl,
                       input logic [1:0] w, input logic m, input logic [15:0] v1, input logic [15:0] v2,
                       input logic [3:0] byp, input logic [15:0] mbv);
    IR = ir; npc_out = npc; E_control = ectl; W_control = w; Mem_control = m;
    VSR1 = v1; VSR2 = v2; Mem_Bypass_Val = mbv;
    {bypass_alu_1, bypass_mem_1, bypass_alu_2, bypass_mem_2} = byp;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".aluout"}, aluout, 16'h0);
    chk({tag, ".pcout"}, pcout, 16'h0);
    chk({tag, ".mdata"}, M_Data, 16'h0);
    chk({tag, ".irexec"}, IR_Exec, 16'h0);
    chk({tag, ".wctl"}, {14'h0, W_Control_out}, 16'h0);
    chk({tag, ".memctl"}, {15'h0, Mem_Control_out}, 16'h0);
    chk({tag, ".dr"}, {13'h0, dr}, 16'h0);
    chk({tag, ".nzp"}, {13'h0, NZP}, 16'h0);
  endtask

  initial begin
    // Reset with random inputs and enable high.
    reset = 1'b0;
    enable_execute = 1'b1;
    drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    tick();
    drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    tick();
    chk_all_zero("reset");
    $display("txn reset: all registered outputs checked for zero");

    // Combinational source indices: STI routes IR[11:9] to sr2.
    IR = 16'hBA42;
    #1;
    chk("sr1_store", {13'h0, sr1}, 16'h0001);
    chk("sr2_store", {13'h0, sr2}, 16'h0005);

    // Register ADD, first instruction after reset release.
    reset = 1'b1;
    drive(16'h1283, 16'h3000, 6'b000001, 2'b10, 1'b1, 16'h0005, 16'h0007, 4'b0000, 16'h0);
    #1;
    chk("sr2_alu", {13'h0, sr2}, 16'h0003);
    tick();
    chk("add.aluout", aluout, 16'h000C);
    chk("add.pcout", pcout, 16'h0288);
    chk("add.dr", {13'h0, dr}, 16'h0001);
    chk("add.nzp", {13'h0, NZP}, 16'h0000);
    chk("add.mdata", M_Data, 16'h0007);
    chk("add.wctl", {14'h0, W_Control_out}, 16'h0002);
    chk("add.memctl", {15'h0, Mem_Control_out}, 16'h0001);
    chk("add.irexec", IR_Exec, 16'h1283);
    $display("txn reg_add: aluout=%h dr=%0d", aluout, dr);

    // Both bypasses on operand 1: previous aluout (0x000C) must win.
    drive(16'h1283, 16'h3000, 6'b000001, 2'b00, 1'b0, 16'h0000, 16'h0007, 4'b1100, 16'h0100);
    tick();
    chk("bypass_prio.aluout", aluout, 16'h0013);
    $display("txn bypass_prio: aluout=%h", aluout);

    // Memory bypass on operand 2 also feeds store data.
    drive(16'h1283, 16'h3000, 6'b000001, 2'b00, 1'b0, 16'h0005, 16'h0007, 4'b0001, 16'h0100);
    tick();
    chk("bypass_mem2.aluout", aluout, 16'h0105);
    chk("bypass_mem2.mdata", M_Data, 16'h0100);
    $display("txn bypass_mem2: aluout=%h mdata=%h", aluout, M_Data);

    // Immediate ADD with imm5 = -1 wraps to 0xFFFF.
    drive(16'h12BF, 16'h3000, 6'b000000, 2'b00, 1'b0, 16'h0000, 16'h1234, 4'b0000, 16'h0);
    tick();
    chk("addimm.aluout", aluout, 16'hFFFF);
    chk("addimm.pcout", pcout, 16'h02BF);
    $display("txn add_imm: aluout=%h", aluout);

    // AND register.
    drive(16'h5283, 16'h3000, 6'b010001, 2'b00, 1'b0, 16'h0F0F, 16'h00FF, 4'b0000, 16'h0);
    tick();
    chk("and.aluout", aluout, 16'h000F);
    $display("txn and: aluout=%h", aluout);

    // NOT.
    drive(16'h927F, 16'h3000, 6'b100000, 2'b00, 1'b0, 16'h00F0, 16'h0000, 4'b0000, 16'h0);
    tick();
    chk("not.aluout", aluout, 16'hFF0F);
    chk("not.dr", {13'h0, dr}, 16'h0001);
    $display("txn not: aluout=%h", aluout);

    // BRnp with PCoffset9 = 5.
    drive(16'h0A05, 16'h3001, 6'b000110, 2'b00, 1'b0, 16'h0000, 16'h0000, 4'b0000, 16'h0);
    tick();
    chk("br.pcout", pcout, 16'h3006);
    chk("br.aluout", aluout, 16'h3006);
    chk("br.nzp", {13'h0, NZP}, 16'h0005);
    chk("br.dr", {13'h0, dr}, 16'h0000);
    $display("txn br: pcout=%h nzp=%b", pcout, NZP);

    // LEA address wrap 0xFFFF + 1 -> 0x0000.
    drive(16'hE401, 16'hFFFF, 6'b000110, 2'b01, 1'b0, 16'h0000, 16'h0000, 4'b0000, 16'h0);
    tick();
    chk("lea.pcout", pcout, 16'h0000);
    chk("lea.aluout", aluout, 16'h0000);
    chk("lea.dr", {13'h0, dr}, 16'h0002);
    $display("txn lea_wrap: pcout=%h", pcout);

    // LDR with offset6 = -2 from a register base.
    drive(16'h6A7E, 16'h3000, 6'b001000, 2'b01, 1'b1, 16'h1000, 16'h0000, 4'b0000, 16'h0);
    tick();
    chk("ldr.pcout", pcout, 16'h0FFE);
    chk("ldr.dr", {13'h0, dr}, 16'h0005);
    $display("txn ldr: pcout=%h dr=%0d", pcout, dr);

    // JMP R7: zero offset, register base, unconditional mask.
    drive(16'hC1C0, 16'h3000, 6'b001100, 2'b11, 1'b1, 16'h4000, 16'h0000, 4'b0000, 16'h0);
    tick();
    chk("jmp.pcout", pcout, 16'h4000);
    chk("jmp.nzp", {13'h0, NZP}, 16'h0007);
    chk("jmp.dr", {13'h0, dr}, 16'h0000);
    $display("txn jmp: pcout=%h nzp=%b", pcout, NZP);

    // Stall three cycles with changing inputs.
    enable_execute = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(16'h1000 + 16'(i), 16'h5555, 6'b000001, 2'b01, 1'b0, 16'(i), 16'h7777, 4'b0000, 16'h0);
      tick();
      chk("stall.pcout", pcout, 16'h4000);
      chk("stall.aluout", aluout, 16'h4000);
      chk("stall.irexec", IR_Exec, 16'hC1C0);
`ifdef LC3_EXEC_BUBBLE_EN
      chk("stall.nzp", {13'h0, NZP}, 16'h0000);
      chk("stall.wctl", {14'h0, W_Control_out}, 16'h0000);
      chk("stall.memctl", {15'h0, Mem_Control_out}, 16'h0000);
`else
      chk("stall.nzp", {13'h0, NZP}, 16'h0007);
      chk("stall.wctl", {14'h0, W_Control_out}, 16'h0003);
      chk("stall.memctl", {15'h0, Mem_Control_out}, 16'h0001);
`endif
      $display("txn stall%0d: pcout=%h nzp=%b", i, pcout, NZP);
    end

    // Mid-operation reset discards the in-flight instruction.
    enable_execute = 1'b1;
    reset = 1'b0;
    drive(16'h1283, 16'h3000, 6'b000001, 2'b10, 1'b1, 16'h0005, 16'h0007, 4'b0000, 16'h0);
    tick();
    chk_all_zero("midreset");
    $display("txn mid_reset: outputs checked for zero");

    // Release and confirm one-cycle latency again.
    reset = 1'b1;
    drive(16'h1283, 16'h3000, 6'b000001, 2'b10, 1'b1, 16'h0001, 16'h0002, 4'b0000, 16'h0);
    tick();
    chk("post.aluout", aluout, 16'h0003);
    chk("post.irexec", IR_Exec, 16'h1283);
    $display("txn post_reset_add: aluout=%h", aluout);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
